// File: rtl/dma_prio_arbiter.sv
// DREQ arbiter and bus-hold sequencer: synchronise/normalise requests, raise HRQ, grant on HLDA.
// DREQ edge to HRQ takes SYNC_STAGES+1 clocks; HLDA to DACK takes 1 clock; grant held until xfer_done or HLDA drop.
module dma_prio_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                  CLK,
    input  logic                                  RESET_N,
    input  logic [NUM_CH-1:0]                     DREQ,
    output logic [NUM_CH-1:0]                     DACK,
    output logic                                  HRQ,
    input  logic                                  HLDA,
    input  logic [NUM_CH-1:0]                     sw_req,
    input  logic [NUM_CH-1:0]                     mask,
    input  logic                                  ctrl_disable,
    input  logic                                  rot_en,
    input  logic                                  dreq_low,
    input  logic                                  dack_high,
    input  logic                                  xfer_done,
    output logic                                  grant_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grant_ch,
    output logic [NUM_CH-1:0]                     sw_ack
);

    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CHW:0] NCH = (CHW+1)'(NUM_CH);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, HOLD_REQ, GRANT, RELEASE} state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] hw_req, eff_req, dack_raw;
    logic [CHW-1:0]    ptr, ptr_eff, win, cand;
    logic [CHW:0]      idx;
    logic              pend, found, sw_hit;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= DREQ;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign hw_req  = sync_q[SYNC_STAGES-1] ^ {NUM_CH{dreq_low}};
    assign eff_req = (hw_req & ~mask) | sw_req;
    assign pend    = (|eff_req) & ~ctrl_disable;
    assign ptr_eff = rot_en ? ptr : '0;

    // Search starts at ptr and wraps at NUM_CH, which need not be a power of two.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, ptr_eff} + (CHW+1)'(i);
            if (idx >= NCH) idx = idx - NCH;
            cand = idx[CHW-1:0];
            if (!found && eff_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pend) state_nxt = HOLD_REQ;
            HOLD_REQ: if (HLDA) state_nxt = pend ? GRANT : RELEASE;
            GRANT:    if (xfer_done || !HLDA) state_nxt = RELEASE;
            RELEASE:  if (!HLDA) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        HRQ = (state == HOLD_REQ) || (state == GRANT);
    end

    // Grant state is latched at HLDA and frozen until completion or preemption.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            grant_valid <= 1'b0;
            grant_ch    <= '0;
            dack_raw    <= '0;
            sw_hit      <= 1'b0;
            sw_ack      <= '0;
            ptr         <= '0;
        end else begin
            sw_ack <= '0;
            if (state == HOLD_REQ && HLDA && pend) begin
                grant_valid <= 1'b1;
                grant_ch    <= win;
                dack_raw    <= NUM_CH'(1) << win;
                sw_hit      <= sw_req[win];
            end else if (state == GRANT && (xfer_done || !HLDA)) begin
                grant_valid <= 1'b0;
                dack_raw    <= '0;
                if (xfer_done) begin
                    if (sw_hit) sw_ack <= dack_raw;
                    if (rot_en) ptr <= (grant_ch == LAST_CH) ? '0 : grant_ch + CHW'(1);
                end
            end
            if (!rot_en) ptr <= '0;
        end
    end

    assign DACK = dack_raw ^ {NUM_CH{~dack_high}};

endmodule

// File: tb/tb_dma_prio_arbiter.sv
// Directed bench: a 4-channel and a 5-channel arbiter driven with hand-computed vectors.
module tb_dma_prio_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] dreq, dack, sw_req, mask, sw_ack;
    logic       hrq, hlda, ctrl_disable, rot_en, dreq_low, dack_high, xfer_done, grant_valid;
    logic [1:0] grant_ch;

    logic [4:0] dreq5, dack5, sw_ack5;
    logic       hrq5, hlda5, xfer5, gv5;
    logic [2:0] gch5;
    logic [4:0] zero5 = 5'b0;
    logic       one = 1'b1, zero = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    dma_prio_arbiter #(.NUM_CH(4), .SYNC_STAGES(2)) dut4 (
        .CLK(clk), .RESET_N(rst_n), .DREQ(dreq), .DACK(dack), .HRQ(hrq), .HLDA(hlda),
        .sw_req(sw_req), .mask(mask), .ctrl_disable(ctrl_disable), .rot_en(rot_en),
        .dreq_low(dreq_low), .dack_high(dack_high), .xfer_done(xfer_done),
        .grant_valid(grant_valid), .grant_ch(grant_ch), .sw_ack(sw_ack));

    dma_prio_arbiter #(.NUM_CH(5), .SYNC_STAGES(2)) dut5 (
        .CLK(clk), .RESET_N(rst_n), .DREQ(dreq5), .DACK(dack5), .HRQ(hrq5), .HLDA(hlda5),
        .sw_req(zero5), .mask(zero5), .ctrl_disable(zero), .rot_en(one),
        .dreq_low(zero), .dack_high(one), .xfer_done(xfer5),
        .grant_valid(gv5), .grant_ch(gch5), .sw_ack(sw_ack5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for HRQ, grants, completes; optionally drops DREQ with the completion.
    task automatic run_grant(input bit last, output logic [1:0] ch, output logic [3:0] dk, output bit to);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (hrq) begin to = 1'b0; break; end
            tick();
        end
        hlda = 1'b1;
        tick();
        ch = grant_ch;
        dk = dack;
        xfer_done = 1'b1;
        if (last) dreq = 4'b0;
        tick();
        xfer_done = 1'b0;
        hlda = 1'b0;
        tick();
    endtask

    task automatic run_grant5(input bit last, output logic [2:0] ch, output logic [4:0] dk, output bit to);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (hrq5) begin to = 1'b0; break; end
            tick();
        end
        hlda5 = 1'b1;
        tick();
        ch = gch5;
        dk = dack5;
        xfer5 = 1'b1;
        if (last) dreq5 = 5'b0;
        tick();
        xfer5 = 1'b0;
        hlda5 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dreq = '0; hlda = 0; sw_req = '0; mask = '0; ctrl_disable = 0;
        rot_en = 0; dreq_low = 0; dack_high = 1; xfer_done = 0;
        dreq5 = '0; hlda5 = 0; xfer5 = 0;
        #3;
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL rst_hrq: got %b want 0", hrq); end
        vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL rst_gv: got %b want 0", grant_valid); end
        vectors++; if (grant_ch !== 2'd0) begin miscompares++; $display("FAIL rst_gch: got %0d want 0", grant_ch); end
        vectors++; if (sw_ack !== 4'b0) begin miscompares++; $display("FAIL rst_swack: got %b want 0000", sw_ack); end
        vectors++; if (dack !== 4'b0000) begin miscompares++; $display("FAIL rst_dack_hi: got %b want 0000", dack); end
        vectors++; if (dack5 !== 5'b00000) begin miscompares++; $display("FAIL rst_dack5: got %b want 00000", dack5); end
        dack_high = 0;
        #1;
        vectors++; if (dack !== 4'b1111) begin miscompares++; $display("FAIL rst_dack_lo: got %b want 1111", dack); end
        dack_high = 1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL rst_idle_hrq: got %b want 0", hrq); end
    endtask

    task automatic test_fixed();
        dreq = 4'b1010;
        tick(); tick();
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL t1_hrq_early: got %b want 0", hrq); end
        tick();
        vectors++; if (hrq !== 1'b1) begin miscompares++; $display("FAIL t1_hrq_rise: got %b want 1", hrq); end
        tick(); tick(); tick();
        vectors++; if (dack !== 4'b0000) begin miscompares++; $display("FAIL t1_dack_wait: got %b want 0000", dack); end
        hlda = 1'b1;
        tick();
        vectors++; if (dack !== 4'b0010) begin miscompares++; $display("FAIL t1_dack: got %b want 0010", dack); end
        vectors++; if (grant_ch !== 2'd1) begin miscompares++; $display("FAIL t1_gch: got %0d want 1", grant_ch); end
        vectors++; if (grant_valid !== 1'b1) begin miscompares++; $display("FAIL t1_gv: got %b want 1", grant_valid); end
        xfer_done = 1'b1; dreq = 4'b0;
        tick();
        xfer_done = 1'b0;
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL t1_hrq_done: got %b want 0", hrq); end
        vectors++; if (dack !== 4'b0000) begin miscompares++; $display("FAIL t1_dack_done: got %b want 0000", dack); end
        vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL t1_gv_done: got %b want 0", grant_valid); end
        hlda = 1'b0;
        tick(); tick();
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL t1_hrq_idle: got %b want 0", hrq); end
    endtask

    task automatic test_disable();
        logic [1:0] ch; logic [3:0] dk; bit to;
        ctrl_disable = 1'b1; dreq = 4'b1001;
        tick(); tick(); tick(); tick();
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL dis_hrq: got %b want 0", hrq); end
        ctrl_disable = 1'b0;
        run_grant(1'b1, ch, dk, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL dis_timeout: HRQ never rose"); end
        vectors++; if (ch !== 2'd0) begin miscompares++; $display("FAIL dis_gch: got %0d want 0", ch); end
    endtask

    task automatic test_rotate();
        logic [1:0] ch; logic [3:0] dk, e; bit to;
        rot_en = 1'b1; dreq = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            e = 4'b0001 << k;
            run_grant(k == 3, ch, dk, to);
            vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL rot_timeout[%0d]: HRQ never rose", k); end
            vectors++; if (ch !== 2'(k)) begin miscompares++; $display("FAIL rot_gch[%0d]: got %0d want %0d", k, ch, k); end
            vectors++; if (dk !== e) begin miscompares++; $display("FAIL rot_dack[%0d]: got %b want %b", k, dk, e); end
        end
        vectors++; if (dut4.ptr !== 2'd0) begin miscompares++; $display("FAIL rot_ptr: got %0d want 0", dut4.ptr); end
    endtask

    task automatic test_wrap5();
        logic [2:0] ch; logic [4:0] dk; bit to;
        dreq5 = 5'b10000;
        run_grant5(1'b1, ch, dk, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL w5_timeout: HRQ never rose"); end
        vectors++; if (ch !== 3'd4) begin miscompares++; $display("FAIL w5_gch4: got %0d want 4", ch); end
        vectors++; if (dut5.ptr !== 3'd0) begin miscompares++; $display("FAIL w5_ptr_wrap: got %0d want 0", dut5.ptr); end
        dreq5 = 5'b11111;
        run_grant5(1'b1, ch, dk, to);
        vectors++; if (ch !== 3'd0) begin miscompares++; $display("FAIL w5_gch0: got %0d want 0", ch); end
        vectors++; if (dk !== 5'b00001) begin miscompares++; $display("FAIL w5_dack: got %b want 00001", dk); end
        vectors++; if (dut5.ptr !== 3'd1) begin miscompares++; $display("FAIL w5_ptr1: got %0d want 1", dut5.ptr); end
    endtask

    task automatic test_polarity();
        rot_en = 1'b0; mask = 4'b1111; dreq_low = 1'b1; dreq = 4'b1111; dack_high = 1'b0;
        tick(); tick(); tick();
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL pol_hrq_idle: got %b want 0", hrq); end
        vectors++; if (dack !== 4'b1111) begin miscompares++; $display("FAIL pol_dack_idle: got %b want 1111", dack); end
        mask = 4'b0001; dreq = 4'b1110; sw_req = 4'b0001;
        for (int i = 0; i < 10 && !hrq; i++) tick();
        vectors++; if (hrq !== 1'b1) begin miscompares++; $display("FAIL pol_hrq: got %b want 1", hrq); end
        hlda = 1'b1;
        tick();
        vectors++; if (grant_ch !== 2'd0) begin miscompares++; $display("FAIL pol_gch: got %0d want 0", grant_ch); end
        vectors++; if (dack !== 4'b1110) begin miscompares++; $display("FAIL pol_dack: got %b want 1110", dack); end
        vectors++; if (sw_ack !== 4'b0000) begin miscompares++; $display("FAIL pol_swack_early: got %b want 0000", sw_ack); end
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        vectors++; if (sw_ack !== 4'b0001) begin miscompares++; $display("FAIL pol_swack: got %b want 0001", sw_ack); end
        vectors++; if (dack !== 4'b1111) begin miscompares++; $display("FAIL pol_dack_rel: got %b want 1111", dack); end
        sw_req = 4'b0; hlda = 1'b0;
        tick();
        vectors++; if (sw_ack !== 4'b0000) begin miscompares++; $display("FAIL pol_swack_pulse: got %b want 0000", sw_ack); end
        mask = 4'b1111; dreq = 4'b0;
        tick(); tick(); tick();
        dreq_low = 1'b0; mask = 4'b0; dack_high = 1'b1;
        tick();
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL pol_restore: got %b want 0", hrq); end
    endtask

    task automatic test_preempt();
        rot_en = 1'b1; dreq = 4'b0101;
        for (int i = 0; i < 10 && !hrq; i++) tick();
        vectors++; if (hrq !== 1'b1) begin miscompares++; $display("FAIL pre_hrq: got %b want 1", hrq); end
        hlda = 1'b1;
        tick();
        vectors++; if (dack !== 4'b0001) begin miscompares++; $display("FAIL pre_dack: got %b want 0001", dack); end
        hlda = 1'b0;
        tick();
        vectors++; if (dack !== 4'b0000) begin miscompares++; $display("FAIL pre_dack_drop: got %b want 0000", dack); end
        vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL pre_gv: got %b want 0", grant_valid); end
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL pre_hrq_low: got %b want 0", hrq); end
        vectors++; if (sw_ack !== 4'b0000) begin miscompares++; $display("FAIL pre_swack: got %b want 0000", sw_ack); end
        vectors++; if (dut4.ptr !== 2'd0) begin miscompares++; $display("FAIL pre_ptr: got %0d want 0", dut4.ptr); end
        tick();
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL pre_hrq_gap: got %b want 0", hrq); end
        tick();
        vectors++; if (hrq !== 1'b1) begin miscompares++; $display("FAIL pre_hrq_again: got %b want 1", hrq); end
        hlda = 1'b1;
        tick();
        vectors++; if (grant_ch !== 2'd0) begin miscompares++; $display("FAIL pre_regrant: got %0d want 0", grant_ch); end
        xfer_done = 1'b1; dreq = 4'b0;
        tick();
        xfer_done = 1'b0; hlda = 1'b0;
        tick();
        vectors++; if (dut4.ptr !== 2'd1) begin miscompares++; $display("FAIL pre_ptr_done: got %0d want 1", dut4.ptr); end
        rot_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dack_high = 1'b0; dreq = 4'b0010;
        for (int i = 0; i < 10 && !hrq; i++) tick();
        hlda = 1'b1;
        tick();
        vectors++; if (dack !== 4'b1101) begin miscompares++; $display("FAIL rm_dack: got %b want 1101", dack); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL rm_hrq: got %b want 0", hrq); end
        vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL rm_gv: got %b want 0", grant_valid); end
        vectors++; if (dack !== 4'b1111) begin miscompares++; $display("FAIL rm_dack_rst: got %b want 1111", dack); end
        hlda = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        vectors++; if (hrq !== 1'b0) begin miscompares++; $display("FAIL rm_hrq_sync: got %b want 0", hrq); end
        tick();
        vectors++; if (hrq !== 1'b1) begin miscompares++; $display("FAIL rm_hrq_restart: got %b want 1", hrq); end
        hlda = 1'b1;
        tick();
        vectors++; if (grant_ch !== 2'd1) begin miscompares++; $display("FAIL rm_gch: got %0d want 1", grant_ch); end
        xfer_done = 1'b1; dreq = 4'b0;
        tick();
        xfer_done = 1'b0; hlda = 1'b0;
        tick();
        vectors++; if (dack !== 4'b1111) begin miscompares++; $display("FAIL rm_dack_end: got %b want 1111", dack); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_disable();
        test_rotate();
        test_wrap5();
        test_polarity();
        test_preempt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_prio_arbiter.md
Name: dma_prio_arbiter

Overview:
- Parametrised DREQ arbiter and bus-hold sequencer for the DMA controller.
- Normalises DREQ polarity and applies masks and software requests, then raises HRQ and waits for HLDA.
- Grants one channel using fixed or rotating priority, drives DACK at the programmed polarity, and holds the grant until the timing block reports end of service.
- Successor to the fixed 4-channel priority logic: adds channel count, an explicit HRQ/HLDA handshake, grant latching and HLDA preemption.

Parameters:
- NUM_CH, 4: number of DMA channels; legal range 2..16, need not be a power of two.
- SYNC_STAGES, 2: DREQ synchroniser depth; legal range 1..3.
- CHW (localparam), max(1, clog2(NUM_CH)): width of the channel index.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DREQ  in  NUM_CH  raw device requests, asynchronous to CLK.
- DACK  out  NUM_CH  device acknowledges, at the programmed polarity.
- HRQ  out  1  hold request to the CPU, active high.
- HLDA  in  1  hold acknowledge from the CPU, active high.
- sw_req  in  NUM_CH  software request bits from the request register.
- mask  in  NUM_CH  channel mask bits; 1 = hardware DREQ ignored.
- ctrl_disable  in  1  command bit 2; 1 = no new arbitration.
- rot_en  in  1  1 = rotating priority, 0 = fixed priority.
- dreq_low  in  1  1 = DREQ is active low.
- dack_high  in  1  1 = DACK is active high.
- xfer_done  in  1  one-cycle pulse from the timing block: granted service finished.
- grant_valid  out  1  a channel currently owns the bus.
- grant_ch  out  CHW  index of the granted channel.
- sw_ack  out  NUM_CH  one-cycle one-hot pulse: clears the serviced software request.

Behaviour:
- Reset (async assert, sync deassert):
  - HRQ=0, grant_valid=0, grant_ch=0, sw_ack=0.
  - Internal dack_raw=0; synchronisers cleared; priority pointer ptr=0; FSM=IDLE.
- DACK is combinational from dack_raw and dack_high: DACK = dack_raw XOR {NUM_CH{~dack_high}}. In reset, DACK is therefore all-ones when dack_high=0 and all-zeros when dack_high=1.
- Request path:
  - hw_req = sync(DREQ) XOR {NUM_CH{dreq_low}}.
  - eff_req = (hw_req & ~mask) | sw_req. Software requests ignore mask.
  - pend = |eff_req & ~ctrl_disable.
- Priority:
  - Fixed (rot_en=0): channel 0 highest, NUM_CH-1 lowest; ptr is held at 0.
  - Rotating (rot_en=1): search order is ptr, ptr+1, ..., wrapping modulo NUM_CH (not modulo 2^CHW).
  - On a completed grant with rot_en=1: ptr <= (grant_ch+1) mod NUM_CH, so the serviced channel becomes lowest priority.
- FSM:
  - IDLE: if pend, go to HOLD_REQ; HRQ=1 from the next cycle.
  - HOLD_REQ: HRQ=1 held regardless of request changes.
    - On HLDA=1 with pend: arbitrate eff_req in that cycle, latch the winner, go to GRANT.
    - On HLDA=1 with no pend: go to RELEASE.
  - GRANT:
    - grant_valid=1, grant_ch=winner, dack_raw=onehot(winner); all registered, so visible the cycle after HLDA is sampled.
    - Winner is frozen; new or dropped requests are ignored.
    - On xfer_done: rotate if rot_en; pulse sw_ack[winner] if sw_req[winner] was set at grant time; go to RELEASE.
    - On HLDA=0 (preemption): go to RELEASE with no rotation and no sw_ack.
    - If xfer_done and HLDA=0 arrive in the same cycle, xfer_done wins.
  - RELEASE:
    - HRQ=0, grant_valid=0, dack_raw=0.
    - Wait for HLDA=0, then go to IDLE. Minimum one cycle in RELEASE, so HRQ is low for at least one cycle between grants.
- Latency: a DREQ edge reaches HRQ after SYNC_STAGES+1 clocks; HLDA sampled high to DACK active takes 1 clock.
- ctrl_disable asserted mid-grant does not abort the grant; it blocks only the next IDLE→HOLD_REQ transition.
- Changes to dreq_low, dack_high or rot_en are applied immediately. Software must change them only in IDLE; no behaviour is defined otherwise beyond no X propagation.
- Reset asserted mid-grant: all outputs take their reset values immediately, with no clock required.

Test Plan:
1. NUM_CH=4, fixed priority, DREQ=4'b1010 active high, HLDA 3 cycles after HRQ.
   - HRQ rises 3 clocks after DREQ.
   - DACK=4'b0010 one clock after HLDA; grant_ch=1.
   - After xfer_done: HRQ=0 and DACK=0000.
2. Rotating priority, DREQ=1111 held, 4 grant/xfer_done cycles.
   - grant_ch sequence 0,1,2,3.
   - ptr back to 0 afterwards.
3. NUM_CH=5, rotating priority, DREQ only on ch4 then ch0.
   - ptr wraps 4→0 (not to 5).
   - The next arbitration with DREQ=11111 grants ch0.
4. dreq_low=1, dack_high=0, mask=0001, DREQ=1110, sw_req=0001.
   - Masked ch0 still wins via software request; DACK=1110.
   - On xfer_done, sw_ack=0001 for exactly one cycle.
5. Preemption: HLDA dropped during GRANT.
   - DACK goes inactive next clock; no sw_ack; ptr unchanged.
   - HRQ stays low while HLDA=0, then re-raises while the request is still pending.
6. RESET_N pulsed low mid-GRANT with no clock edge.
   - HRQ=0, grant_valid=0, DACK at inactive level immediately.
   - After release, a pending DREQ restarts from IDLE.
